// File: rtl/bnn_accum.sv
// Binary-neuron accumulator: sums XNOR-popcount words per neuron, thresholds,
// and packs up to 32 activation bits into one output word.
module bnn_accum #(
    parameter int ACC_W = 14
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [7:0]       NumWords,
    input  logic [ACC_W-1:0] Threshold,
    input  logic             flush,
    input  logic             pc_valid,
    input  logic [5:0]       pc_data,
    output logic             pc_ready,
    output logic             act_valid,
    output logic [31:0]      act_data,
    output logic [5:0]       act_count,
    input  logic             act_ready,
    output logic             busy
);

    typedef enum logic [1:0] {
        IDLE,
        ACCUM,
        OUT
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [ACC_W-1:0] acc;
    logic [ACC_W-1:0] thr;
    logic [ACC_W-1:0] sum;
    logic [7:0]       wcnt;
    logic [31:0]      pack;
    logic [5:0]       idx;

    logic take_flush;
    logic take_start;
    logic xfer;
    logic last;
    logic act_bit;
    logic fire;

    // Handshake outputs come straight from the state register.
    assign pc_ready  = (state == ACCUM);
    assign act_valid = (state == OUT);
    assign busy      = (state != IDLE);
    assign act_data  = pack;
    assign act_count = idx;

    always_comb begin
        take_flush = (state == IDLE) && flush && (idx != 6'd0);
        take_start = (state == IDLE) && start && (NumWords != 8'd0)
                     && !take_flush;
        xfer       = pc_ready && pc_valid;
        last       = xfer && (wcnt == 8'd1);
        sum        = acc + {{(ACC_W-6){1'b0}}, pc_data};
        act_bit    = (sum >= thr);
        fire       = act_valid && act_ready;
    end

    always_comb begin
        state_nxt = state;
        unique case (1'b1)
            take_flush: state_nxt = OUT;
            take_start: state_nxt = ACCUM;
            last:       state_nxt = (idx == 6'd31) ? OUT : IDLE;
            fire:       state_nxt = IDLE;
            default:    state_nxt = state;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            acc  <= '0;
            thr  <= '0;
            wcnt <= 8'd0;
            pack <= 32'd0;
            idx  <= 6'd0;
        end else begin
            if (take_start) begin
                acc  <= '0;
                wcnt <= NumWords;
                thr  <= Threshold;
            end
            if (xfer) begin
                acc  <= sum;
                wcnt <= wcnt - 8'd1;
            end
            // Activation bit lands on the same edge as the final word.
            if (last) begin
                pack[idx[4:0]] <= act_bit;
                idx            <= idx + 6'd1;
            end
            if (fire) begin
                pack <= 32'd0;
                idx  <= 6'd0;
            end
        end
    end

endmodule

// File: doc/bnn_accum.md
BNN_ACCUM -- requirements
Module: bnn_accum

Interface
REQ-001 Parameter: ACC_W, default 14, accumulator and threshold width; SHALL be >= 14 so that 255*32 = 8160 cannot overflow.
REQ-002 Port: clk  input  1  single clock; all state updates on the rising edge.
REQ-003 Port: reset  input  1  asynchronous, active-high reset.
REQ-004 Port: start  input  1  pulse that begins one neuron; sampled only in IDLE.
REQ-005 Port: NumWords  input  8  number of 32-bit popcount words per neuron, captured on an accepted start.
REQ-006 Port: Threshold  input  ACC_W  activation threshold, captured on an accepted start.
REQ-007 Port: flush  input  1  request to emit a partially packed activation word; sampled only in IDLE.
REQ-008 Port: pc_valid  input  1  popcount word valid.
REQ-009 Port: pc_data  input  6  upstream XNOR-popcount result, range 0..32.
REQ-010 Port: pc_ready  output  1  asserted only in ACCUM.
REQ-011 Port: act_valid  output  1  packed activation word valid; asserted only in OUT.
REQ-012 Port: act_data  output  32  packed activation bits; bit i is neuron i of the group.
REQ-013 Port: act_count  output  6  number of valid bits in act_data, range 1..32.
REQ-014 Port: act_ready  input  1  downstream accepts the activation word.
REQ-015 Port: busy  output  1  high whenever state != IDLE.

Function
REQ-016 The block SHALL implement the states IDLE, ACCUM and OUT.
REQ-017 In IDLE, when flush=1 and the bit index is nonzero, the next state SHALL be OUT; flush wins over a simultaneous start, and that start is dropped.
REQ-018 In IDLE, when start=1, NumWords!=0 and no flush is taken, the block SHALL clear the accumulator, load the word counter from NumWords, latch Threshold, and move to ACCUM.
REQ-019 start with NumWords=0, flush with bit index 0, and start or flush outside IDLE SHALL be ignored with no state change.
REQ-020 In ACCUM, a transfer SHALL occur on pc_valid & pc_ready; each transfer adds zero-extended pc_data to the accumulator and decrements the word counter. Cycles with pc_valid=0 SHALL leave all state unchanged.
REQ-021 On the transfer that decrements the word counter to 0, the block SHALL write the activation bit ((acc + pc_data) >= Threshold, unsigned) into bit [idx] of the pack register and increment idx, all on the same edge.
REQ-022 After that final transfer, the next state SHALL be OUT if idx was 31, and IDLE otherwise.
REQ-023 Latency: act_valid SHALL assert on the cycle immediately after the final transfer of the 32nd neuron. A new start SHALL be accepted no earlier than the cycle after the final transfer.
REQ-024 In OUT, act_data SHALL equal the pack register, with unused upper bits 0, and act_count SHALL equal idx (32 for a full group).
REQ-025 In OUT, act_data and act_count SHALL remain stable while act_ready=0.
REQ-026 On act_valid & act_ready, the block SHALL clear the pack register and idx and return to IDLE.
REQ-027 The accumulator SHALL NOT wrap or saturate within the legal range (<= 8160). pc_data > 32 is illegal input, and the resulting behaviour is unspecified.
REQ-028 pc_ready, act_valid and busy SHALL be driven directly from the state register, not combinationally from inputs.

Reset
REQ-029 While reset=1, the block SHALL immediately force state=IDLE and clear the accumulator, word counter, latched threshold, pack register and idx, independent of clk.
REQ-030 Out of reset: pc_ready=0, act_valid=0, act_data=0, act_count=0, busy=0.
REQ-031 A reset asserted mid-ACCUM or mid-OUT SHALL discard the partial neuron and any pending word; the first start after reset SHALL begin from idx 0.

Verification
REQ-032 NumWords=1, Threshold=16; 32 neurons with pc_data alternating 16 and 15 -> act_valid one cycle after the last transfer, act_data=0x55555555, act_count=32.
REQ-033 NumWords=255, all pc_data=32: Threshold=8160 gives bit=1; Threshold=8161 gives bit=0.
REQ-034 Three neurons giving bits 1,0,1, then flush -> act_data=0x00000005, act_count=3; flush again in IDLE with idx 0 -> no act_valid.
REQ-035 act_ready held low for 5 cycles in OUT -> act_valid stays 1, data stable, busy=1, start ignored; act_ready=1 -> IDLE the next cycle, with the next group starting at bit 0.
REQ-036 NumWords=4 with random pc_valid gaps, reset asserted after 2 transfers -> all outputs 0 immediately; the following neuron accumulates only post-reset words.
REQ-037 start with NumWords=0 -> stays IDLE with pc_ready=0; start and flush together with idx=2 -> OUT with act_count=2.
